// File: rtl/bcd_pkg.sv
// Shared widths, 7-segment patterns and elaboration-time helpers for the BCD counter.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;

  // Patterns are {a,b,c,d,e,f,g}, active-high.
  localparam logic [SEG_W-1:0] SEG_0   = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1   = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2   = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3   = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4   = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5   = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6   = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7   = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8   = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9   = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;

  // Packs the low 'digits' decimal digits of value into BCD, digit 0 in [3:0].
  function automatic logic [31:0] to_bcd(input int value, input int digits);
    logic [31:0] r;
    int          v;
    r = '0;
    v = value;
    for (int i = 0; i < 8; i++) begin
      if (i < digits) begin
        r[4*i +: 4] = 4'(v % 10);
        v           = v / 10;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_seg7.sv
// Single-digit BCD to 7-segment decoder; codes 10..15 blank the digit.
module seg7_decode
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   pattern
);

  always_comb begin
    pattern = SEG_OFF;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter (0..LIMIT) with load, terminal count and per-digit 7-seg decode.
// Defining BCD_COUNTER_SATURATE_EN replaces wrap-around with saturation and adds the sat flag.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int LIMIT  = 99
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      up,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic [SEG_W*DIGITS-1:0]   seg,
  output logic                      tc
`ifdef BCD_COUNTER_SATURATE_EN
  ,
  output logic                      sat
`endif
);

  localparam int              W         = DIGIT_W * DIGITS;
  localparam logic [31:0]     LIMIT_ALL = to_bcd(LIMIT, DIGITS);
  localparam logic [W-1:0]    LIMIT_BCD = LIMIT_ALL[W-1:0];

  logic [W-1:0]      load_clip;
  logic [W-1:0]      load_fit;
  logic [W-1:0]      inc_val;
  logic [W-1:0]      dec_val;
  logic [W-1:0]      next_val;
  logic [DIGITS-1:0] carry;
  logic [DIGITS-1:0] borrow;
  logic              at_limit;
  logic              at_zero;

  // Digit i steps only when every lower digit is at its roll-over value.
  always_comb begin
    carry     = '0;
    borrow    = '0;
    carry[0]  = 1'b1;
    borrow[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      carry[i]  = carry[i-1]  & (bcd[4*(i-1) +: 4] == 4'd9);
      borrow[i] = borrow[i-1] & (bcd[4*(i-1) +: 4] == 4'd0);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [DIGIT_W-1:0] d;
    logic [DIGIT_W-1:0] ld;

    assign d  = bcd[4*g +: 4];
    assign ld = load_val[4*g +: 4];

    assign load_clip[4*g +: 4] = (ld > 4'd9) ? 4'd9 : ld;
    assign inc_val[4*g +: 4]   = !carry[g]  ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
    assign dec_val[4*g +: 4]   = !borrow[g] ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);

    seg7_decode u_seg (
      .digit   (d),
      .pattern (seg[7*g +: 7])
    );
  end

  // With every digit <= 9, numeric vector compare equals MSD-first digit compare.
  assign load_fit = (load_clip > LIMIT_BCD) ? LIMIT_BCD : load_clip;
  assign at_limit = (bcd == LIMIT_BCD);
  assign at_zero  = (bcd == '0);
  assign tc       = en & ((up & at_limit) | (~up & at_zero));

`ifdef BCD_COUNTER_SATURATE_EN
  logic blocked;
`endif

  always_comb begin
    next_val = bcd;
`ifdef BCD_COUNTER_SATURATE_EN
    blocked  = 1'b0;
`endif
    if (load) begin
      next_val = load_fit;
    end else if (en) begin
      if (up) begin
        if (at_limit) begin
`ifdef BCD_COUNTER_SATURATE_EN
          blocked  = 1'b1;
`else
          next_val = '0;
`endif
        end else begin
          next_val = inc_val;
        end
      end else begin
        if (at_zero) begin
`ifdef BCD_COUNTER_SATURATE_EN
          blocked  = 1'b1;
`else
          next_val = LIMIT_BCD;
`endif
        end else begin
          next_val = dec_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd <= '0;
    end else begin
      bcd <= next_val;
    end
  end

`ifdef BCD_COUNTER_SATURATE_EN
  // sat reflects the most recent enabled step; idle cycles leave it untouched.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      sat <= 1'b0;
    end else if (en) begin
      sat <= blocked;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomised and directed bench for bcd_updown_counter (LIMIT=99 and LIMIT=59 instances on shared inputs),
// checked against an integer reference model.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        reset, en, up, load;
  logic [7:0]  load_val;
  logic [7:0]  bcd_a, bcd_b;
  logic [13:0] seg_a, seg_b;
  logic        tc_a, tc_b;
`ifdef BCD_COUNTER_SATURATE_EN
  logic        sat_a, sat_b;
`endif

  int checks = 0;
  int errors = 0;
  int m[2];
  bit ms[2];
  int lim[2] = '{99, 59};

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2), .LIMIT(99)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .bcd(bcd_a), .seg(seg_a), .tc(tc_a)
`ifdef BCD_COUNTER_SATURATE_EN
    , .sat(sat_a)
`endif
  );

  bcd_updown_counter #(.DIGITS(2), .LIMIT(59)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .bcd(bcd_b), .seg(seg_b), .tc(tc_b)
`ifdef BCD_COUNTER_SATURATE_EN
    , .sat(sat_b)
`endif
  );

  function automatic logic [7:0] to_bcd2(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] pat(int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [13:0] seg2(int v);
    return {pat(v / 10), pat(v % 10)};
  endfunction

  function automatic int load_num(logic [7:0] lv, int l);
    int hi, lo, v;
    hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
    lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
    v  = hi * 10 + lo;
    return (v > l) ? l : v;
  endfunction

  function automatic bit tc_model(int v, int l);
    return en && ((up && v == l) || (!up && v == 0));
  endfunction

  // Advances the model with the current inputs, then lets the DUTs take the same edge.
  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m[k] = 0; ms[k] = 1'b0;
      end else if (load) begin
        m[k] = load_num(load_val, lim[k]); ms[k] = 1'b0;
      end else if (en) begin
        ms[k] = 1'b0;
        if (up) begin
          if (m[k] == lim[k]) begin
`ifdef BCD_COUNTER_SATURATE_EN
            ms[k] = 1'b1;
`else
            m[k] = 0;
`endif
          end else m[k] = m[k] + 1;
        end else begin
          if (m[k] == 0) begin
`ifdef BCD_COUNTER_SATURATE_EN
            ms[k] = 1'b1;
`else
            m[k] = lim[k];
`endif
          end else m[k] = m[k] - 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; load = 1; en = 1; up = 0; load_val = 8'h47;
    tick();
    checks++;
    if ({bcd_a, bcd_b} !== 16'h0000) begin
      errors++; $display("FAIL reset_bcd: got %h/%h want 00/00", bcd_a, bcd_b);
    end
    checks++;
    if ({seg_a, seg_b} !== {4{7'b1111110}}) begin
      errors++; $display("FAIL reset_seg: got %b/%b want all zero glyphs", seg_a, seg_b);
    end
    checks++;
    if ({tc_a, tc_b} !== 2'b11) begin
      errors++; $display("FAIL reset_tc_down: got %b%b want 11", tc_a, tc_b);
    end
    en = 0; #1;
    checks++;
    if ({tc_a, tc_b} !== 2'b00) begin
      errors++; $display("FAIL reset_tc_idle: got %b%b want 00", tc_a, tc_b);
    end
    reset = 0; load = 0;
  endtask

  task automatic test_count_up();
    reset = 1; load = 0; en = 0; up = 1;
    tick();
    reset = 0; en = 1;
    for (int n = 0; n < 100; n++) begin
      checks++;
      if ({tc_a, tc_b} !== {tc_model(m[0], 99), tc_model(m[1], 59)}) begin
        errors++; $display("FAIL up_tc: step %0d got %b%b want %b%b", n, tc_a, tc_b,
                           tc_model(m[0], 99), tc_model(m[1], 59));
      end
      tick();
      checks++;
      if ({bcd_a, bcd_b} !== {to_bcd2(m[0]), to_bcd2(m[1])}) begin
        errors++; $display("FAIL up_bcd: step %0d got %h/%h want %h/%h", n, bcd_a, bcd_b,
                           to_bcd2(m[0]), to_bcd2(m[1]));
      end
      checks++;
      if ({seg_a, seg_b} !== {seg2(m[0]), seg2(m[1])}) begin
        errors++; $display("FAIL up_seg: step %0d got %b/%b want %b/%b", n, seg_a, seg_b,
                           seg2(m[0]), seg2(m[1]));
      end
      if (m[0] == 42) begin
        checks++;
        if (seg_a !== 14'b0110011_1101101) begin
          errors++; $display("FAIL seg_42: got %b want 01100111101101", seg_a);
        end
      end
    end
  endtask

  task automatic test_count_down();
    logic [7:0] e1, e2;
`ifdef BCD_COUNTER_SATURATE_EN
    e1 = 8'h00; e2 = 8'h00;
`else
    e1 = 8'h99; e2 = 8'h98;
`endif
    reset = 1; load = 0; en = 0; up = 0;
    tick();
    reset = 0; en = 1;
    tick();
    checks++;
    if (bcd_a !== e1) begin
      errors++; $display("FAIL down_wrap: got %h want %h", bcd_a, e1);
    end
    tick();
    checks++;
    if (bcd_a !== e2) begin
      errors++; $display("FAIL down_second: got %h want %h", bcd_a, e2);
    end
    load = 1; load_val = 8'h10; en = 0;
    tick();
    load = 0;
    tick();
    checks++;
    if ({bcd_a, bcd_b} !== 16'h1010) begin
      errors++; $display("FAIL down_hold: got %h/%h want 10/10", bcd_a, bcd_b);
    end
    en = 1;
    tick();
    checks++;
    if ({bcd_a, bcd_b} !== 16'h0909) begin
      errors++; $display("FAIL down_borrow: got %h/%h want 09/09", bcd_a, bcd_b);
    end
  endtask

  task automatic test_load();
    en = 1; up = 1; load = 1; load_val = 8'h57;
    tick();
    checks++;
    if ({bcd_a, bcd_b} !== 16'h5757) begin
      errors++; $display("FAIL load_57: got %h/%h want 57/57", bcd_a, bcd_b);
    end
    load_val = 8'hA3;
    tick();
    checks++;
    if ({bcd_a, bcd_b} !== 16'h9359) begin
      errors++; $display("FAIL load_a3: got %h/%h want 93/59", bcd_a, bcd_b);
    end
    load = 0;
  endtask

  task automatic test_limit59();
    logic [7:0] e;
`ifdef BCD_COUNTER_SATURATE_EN
    e = 8'h59;
`else
    e = 8'h00;
`endif
    en = 1; up = 1; load = 1; load_val = 8'h75;
    tick();
    checks++;
    if ({bcd_a, bcd_b} !== 16'h7559) begin
      errors++; $display("FAIL lim_load75: got %h/%h want 75/59", bcd_a, bcd_b);
    end
    load = 0; #1;
    checks++;
    if (tc_b !== 1'b1) begin
      errors++; $display("FAIL lim_tc: got %b want 1", tc_b);
    end
    tick();
    checks++;
    if (bcd_b !== e) begin
      errors++; $display("FAIL lim_step: got %h want %h", bcd_b, e);
    end
  endtask

  task automatic test_reset_priority();
    load = 1; load_val = 8'h33; en = 0;
    tick();
    reset = 1; load = 1; en = 1; load_val = 8'h77;
    tick();
    reset = 0; load = 0; en = 0; up = 0;
    checks++;
    if ({bcd_a, bcd_b} !== 16'h0000) begin
      errors++; $display("FAIL rst_prio: got %h/%h want 00/00", bcd_a, bcd_b);
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if ({bcd_a, bcd_b, tc_a, tc_b} !== 18'h0) begin
        errors++; $display("FAIL idle_hold: cycle %0d got %h/%h tc %b%b want 00/00 tc 00",
                           n, bcd_a, bcd_b, tc_a, tc_b);
      end
    end
  endtask

`ifdef BCD_COUNTER_SATURATE_EN
  task automatic test_saturate();
    load = 1; load_val = 8'h99; en = 0;
    tick();
    load = 0; en = 1; up = 1;
    tick();
    checks++;
    if ({bcd_a, sat_a} !== {8'h99, 1'b1}) begin
      errors++; $display("FAIL sat_hold: got %h sat %b want 99 sat 1", bcd_a, sat_a);
    end
    up = 0;
    tick();
    checks++;
    if ({bcd_a, sat_a} !== {8'h98, 1'b0}) begin
      errors++; $display("FAIL sat_clear: got %h sat %b want 98 sat 0", bcd_a, sat_a);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up       = $urandom_range(0, 1) == 1;
      load_val = 8'($urandom);
      #1;
      checks++;
      if ({tc_a, tc_b} !== {tc_model(m[0], 99), tc_model(m[1], 59)}) begin
        errors++; $display("FAIL rnd_tc: iter %0d got %b%b want %b%b", n, tc_a, tc_b,
                           tc_model(m[0], 99), tc_model(m[1], 59));
      end
      tick();
      checks++;
      if ({bcd_a, bcd_b} !== {to_bcd2(m[0]), to_bcd2(m[1])}) begin
        errors++; $display("FAIL rnd_bcd: iter %0d got %h/%h want %h/%h", n, bcd_a, bcd_b,
                           to_bcd2(m[0]), to_bcd2(m[1]));
      end
      checks++;
      if ({seg_a, seg_b} !== {seg2(m[0]), seg2(m[1])}) begin
        errors++; $display("FAIL rnd_seg: iter %0d got %b/%b want %b/%b", n, seg_a, seg_b,
                           seg2(m[0]), seg2(m[1]));
      end
`ifdef BCD_COUNTER_SATURATE_EN
      checks++;
      if ({sat_a, sat_b} !== {ms[0], ms[1]}) begin
        errors++; $display("FAIL rnd_sat: iter %0d got %b%b want %b%b", n, sat_a, sat_b, ms[0], ms[1]);
      end
`endif
    end
    reset = 0; load = 0; en = 0;
  endtask

  initial begin
    reset = 1; en = 0; up = 0; load = 0; load_val = 8'h00;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_limit59();
    test_reset_priority();
`ifdef BCD_COUNTER_SATURATE_EN
    test_saturate();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
